z1_rtc_top: RTL and testbench

Top-level real-time-counter block for the Z-1 RTC device. It counts rising edges of an external time-base pin into a 64-bit counter and exposes the count over a mode-0 SPI slave port. All logic runs on `sim_clk`; the SPI pins and the time-base pin are asynchronous and oversampled.

---
 rtl/z1_rtc_pkg.sv | 36 +++
 rtl/z1_rtc_spi_slave.sv | 151 +++++++++++++++
 rtl/z1_rtc_top.sv | 65 ++++++
 tb/tb_z1_rtc_top.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z1_rtc_pkg.sv
// Shared constants and types for the Z-1 RTC block.
// The optional WRITE command is enabled by defining Z1_RTC_WRITE_EN.
package z1_rtc_pkg;

  localparam int RTC_CNT_W  = 64;
  localparam int FRAME_BITS = 72;
  localparam int CMD_BITS   = 8;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h03;

  // Counter word type
  typedef logic [RTC_CNT_W-1:0] rtc_cnt_t;

  // Kind of frame currently in its data phase
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_IS_READ,
    CMD_IS_WRITE
  } cmd_kind_t;

  // Map a received command byte to a frame kind; WRITE only when enabled
  function automatic cmd_kind_t decode_cmd(input logic [CMD_BITS-1:0] cmd,
                                           input logic wr_en);
    cmd_kind_t k;
    k = CMD_NONE;
    if (cmd == CMD_READ) begin
      k = CMD_IS_READ;
    end else if (wr_en && (cmd == CMD_WRITE)) begin
      k = CMD_IS_WRITE;
    end
    return k;
  endfunction

endpackage

// File: rtl/z1_rtc_spi_slave.sv
// SPI mode-0 slave for the Z-1 RTC: input synchronizers, edge detection,
// 72-bit frame counter, command decode, READ snapshot shifter and (when
// Z1_RTC_WRITE_EN is defined) the WRITE load register.
module z1_rtc_spi_slave
  import z1_rtc_pkg::*;
#(
  parameter int CNT_W       = RTC_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sclk_i,
  input  logic             mosi_i,
  input  logic             cs_ni,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             miso_o,
  output logic             tick_o,
  output logic             clr_o,
  output logic             hold_o,
  output logic             load_o,
  output logic [CNT_W-1:0] load_val_o
);

  localparam int NSYNC  = 6;
  localparam int I_SCLK = 0;
  localparam int I_MOSI = 1;
  localparam int I_CSN  = 2;
  localparam int I_TICK = 3;
  localparam int I_CLR  = 4;
  localparam int I_HOLD = 5;

`ifdef Z1_RTC_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] sync_q [SYNC_STAGES];
  logic [NSYNC-1:0] sync_s;

  assign async_in = {hold_i, clr_i, tick_i, cs_ni, mosi_i, sclk_i};

  // Multi-stage synchronizer shared by all asynchronous pins
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  logic sclk_s, mosi_s, cs_n_s, tick_s;
  assign sclk_s = sync_s[I_SCLK];
  assign mosi_s = sync_s[I_MOSI];
  assign cs_n_s = sync_s[I_CSN];
  assign tick_s = sync_s[I_TICK];

  logic sclk_prev_q, tick_prev_q;
  logic sclk_rise, sclk_fall;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign tick_o    = tick_s & ~tick_prev_q;
  assign clr_o     = sync_s[I_CLR];
  assign hold_o    = sync_s[I_HOLD];

  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [CMD_BITS-1:0]  cmd_q;
  logic [CMD_BITS-1:0]  cmd_next;
  cmd_kind_t            kind_q;
  cmd_kind_t            next_kind;
  logic [CNT_W-1:0]     shift_q;
  logic                 miso_q;
  logic                 frame_last, cmd_last, data_phase;

  assign cmd_next   = {cmd_q[CMD_BITS-2:0], mosi_s};
  assign next_kind  = decode_cmd(cmd_next, WR_EN);
  assign frame_last = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
  assign cmd_last   = (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1));
  assign data_phase = (bit_cnt_q >= BIT_CNT_W'(CMD_BITS));

  // Frame sequencing: bit count, command capture, snapshot and MISO shifting
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_prev_q <= 1'b0;
      tick_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      kind_q      <= CMD_NONE;
      shift_q     <= '0;
      miso_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      tick_prev_q <= tick_s;
      if (cs_n_s) begin
        bit_cnt_q <= '0;
        cmd_q     <= '0;
        kind_q    <= CMD_NONE;
        miso_q    <= 1'b0;
      end else if (sclk_rise) begin
        bit_cnt_q <= frame_last ? '0 : bit_cnt_q + 1'b1;
        if (!data_phase) cmd_q <= cmd_next;
        if (cmd_last) begin
          kind_q <= next_kind;
          // Snapshot takes the registered counter, i.e. pre-increment value
          if (next_kind == CMD_IS_READ) shift_q <= cnt_i;
        end
      end else if (sclk_fall) begin
        if (data_phase && (kind_q == CMD_IS_READ)) begin
          miso_q  <= shift_q[CNT_W-1];
          shift_q <= {shift_q[CNT_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign miso_o = miso_q;

`ifdef Z1_RTC_WRITE_EN
  logic [CNT_W-1:0] load_q;
  logic             wr_bit;

  assign wr_bit = !cs_n_s && sclk_rise && data_phase && (kind_q == CMD_IS_WRITE);

  // Collect WRITE data bits MSB-first
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      load_q <= '0;
    end else if (wr_bit) begin
      load_q <= {load_q[CNT_W-2:0], mosi_s};
    end
  end

  // Final data bit is merged in directly so the load lands on rising edge 72
  assign load_o     = wr_bit && frame_last;
  assign load_val_o = {load_q[CNT_W-2:0], mosi_s};
`else
  assign load_o     = 1'b0;
  assign load_val_o = '0;
`endif

endmodule

// File: rtl/z1_rtc_top.sv
// Z-1 RTC top: 64-bit tick counter with clear/hold/load, read over SPI.
// Define Z1_RTC_WRITE_EN to enable the WRITE (0x03) counter preload command.
module z1_rtc_top
  import z1_rtc_pkg::*;
#(
  parameter int CNT_W       = RTC_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic sim_clk,
  input  logic pin22,
  input  logic pin1,
  input  logic pin2,
  output logic pin3,
  input  logic pin4,
  input  logic pin5,
  input  logic pin6,
  input  logic pin7
);

  logic             tick, clr, hold, load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  z1_rtc_spi_slave #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_spi (
    .clk_i      (sim_clk),
    .rst_ni     (pin22),
    .sclk_i     (pin1),
    .mosi_i     (pin2),
    .cs_ni      (pin4),
    .tick_i     (pin5),
    .clr_i      (pin6),
    .hold_i     (pin7),
    .cnt_i      (cnt_q),
    .miso_o     (pin3),
    .tick_o     (tick),
    .clr_o      (clr),
    .hold_o     (hold),
    .load_o     (load),
    .load_val_o (load_val)
  );

  // Counter next state: clear, then load, then hold, then tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge sim_clk) begin
    if (!pin22) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_z1_rtc_top.sv
// Directed testbench for z1_rtc_top. Build with +define+Z1_RTC_WRITE_EN to
// exercise the WRITE preload path; otherwise 0x03 is checked as unknown.
module tb_z1_rtc_top;

  localparam int HALF = 29;
  localparam logic [7:0] RD = 8'h02;

  logic sim_clk = 1'b0;
  logic pin22, pin1, pin2, pin3, pin4, pin5, pin6, pin7;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_cnt;
  logic [63:0] rdata, r1, r2;

  always #5 sim_clk = ~sim_clk;

  z1_rtc_top dut (
    .sim_clk (sim_clk),
    .pin22   (pin22),
    .pin1    (pin1),
    .pin2    (pin2),
    .pin3    (pin3),
    .pin4    (pin4),
    .pin5    (pin5),
    .pin6    (pin6),
    .pin7    (pin7)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sim_clk);
    #1;
  endtask

  // Shift nbits of {cmd, wdata}; collect MISO during data-bit high phases
  task automatic spi_xfer(input logic [7:0] cmd, input logic [63:0] wdata,
                          input int nbits, output logic [63:0] rd);
    logic [71:0] frame;
    frame = {cmd, wdata};
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      pin2 = frame[71-i];
      wait_cycles(HALF);
      pin1 = 1'b1;
      wait_cycles(HALF);
      if (i >= 8) rd = {rd[62:0], pin3};
      pin1 = 1'b0;
    end
    $display("frame cmd=%02h bits=%0d wdata=%016h rdata=%016h", cmd, nbits, wdata, rd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pin5 = 1'b1;
      wait_cycles(3);
      pin5 = 1'b0;
      wait_cycles(3);
    end
  endtask

  task automatic test_reset;
    pin22 = 1'b0; pin1 = 0; pin2 = 0; pin4 = 0; pin5 = 0; pin6 = 0; pin7 = 0;
    wait_cycles(2);
    pin22 = 1'b1;
    wait_cycles(2);
    checks++;
    if (pin3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso: got %b expected 0", pin3);
    end
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_read: got %0d expected 0", rdata);
    end
    exp_cnt = 64'd0;
  endtask

  task automatic test_ticks;
    ticks(10);
    exp_cnt = 64'd10;
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL tick_read: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  // Ticks run every 6 cycles from t=0; snapshots land at cycle 435 and 4611,
  // so 73 and 769 ticks precede them.
  task automatic test_back_to_back;
    fork
      begin
        spi_xfer(RD, 64'd0, 72, r1);
        spi_xfer(RD, 64'd0, 72, r2);
      end
      ticks(800);
    join
    checks++;
    if (r1 !== 64'd83) begin
      errors++;
      $display("FAIL b2b_first: got %0d expected 83", r1);
    end
    checks++;
    if (r2 !== 64'd779) begin
      errors++;
      $display("FAIL b2b_second: got %0d expected 779 (first %0d)", r2, r1);
    end
    exp_cnt = 64'd810;
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_after: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  task automatic test_clear_hold;
    pin6 = 1'b1;
    wait_cycles(1);
    pin6 = 1'b0;
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL clear_read: got %0d expected 0", rdata);
    end
    ticks(5);
    pin7 = 1'b1;
    wait_cycles(5);
    ticks(5);
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== 64'd5) begin
      errors++;
      $display("FAIL hold_read: got %0d expected 5", rdata);
    end
    pin7 = 1'b0;
    wait_cycles(5);
    ticks(3);
    wait_cycles(5);
    exp_cnt = 64'd8;
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL hold_release: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  task automatic test_unknown_cmd;
    spi_xfer(8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 72, rdata);
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL unknown_miso: got %016h expected 0", rdata);
    end
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL unknown_next: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  task automatic test_write;
    spi_xfer(8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 72, rdata);
    checks++;
    if (rdata !== 64'd0) begin
      errors++;
      $display("FAIL write_miso: got %016h expected 0", rdata);
    end
`ifdef Z1_RTC_WRITE_EN
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL write_load: got %016h expected %016h", rdata, exp_cnt);
    end
    ticks(1);
    exp_cnt = exp_cnt + 64'd1;
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL write_wrap: got %016h expected %016h", rdata, exp_cnt);
    end
  endtask

  task automatic test_cs_abort;
    spi_xfer(RD, 64'd0, 30, rdata);
    pin4 = 1'b1;
    wait_cycles(10);
    checks++;
    if (pin3 !== 1'b0) begin
      errors++;
      $display("FAIL cs_miso: got %b expected 0", pin3);
    end
    pin4 = 1'b0;
    wait_cycles(10);
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL cs_restart: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    ticks(4);
    wait_cycles(5);
    spi_xfer(RD, 64'd0, 20, rdata);
    pin22 = 1'b0;
    wait_cycles(2);
    pin22 = 1'b1;
    wait_cycles(HALF);
    exp_cnt = 64'd0;
    spi_xfer(RD, 64'd0, 72, rdata);
    checks++;
    if (rdata !== exp_cnt) begin
      errors++;
      $display("FAIL reset_midframe: got %0d expected %0d", rdata, exp_cnt);
    end
  endtask

  initial begin
    @(posedge sim_clk);
    #1;
    test_reset();
    test_ticks();
    test_back_to_back();
    test_clear_hold();
    test_unknown_cmd();
    test_write();
    test_cs_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
